// File: rtl/number_pkg.sv
// number_pkg
// Shared constants and types for the digit glyph ROM arbiter.
//   GLYPH_*      : glyph geometry; a glyph is GLYPH_W x GLYPH_H pixels, row-major
//   DIGIT_MAX    : highest digit with a glyph in the ROM
//   port_e       : requester identity (time renderer / score renderer)
//   tag_t        : in-flight lookup tag {valid, port, blank}
//   lookup_blank : true when a (digit, pixel index) pair has no ROM entry
package number_pkg;

    localparam int unsigned GLYPH_W      = 10;
    localparam int unsigned GLYPH_H      = 16;
    localparam int unsigned GLYPH_PIXELS = GLYPH_W * GLYPH_H;
    localparam int unsigned DIGIT_MAX    = 9;

    typedef enum logic {
        PORT_T = 1'b0,
        PORT_S = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  blank;
    } tag_t;

    function automatic logic lookup_blank(input int unsigned digit, input int unsigned count);
        return (digit > DIGIT_MAX) || (count >= GLYPH_PIXELS);
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe
// Delay line carrying lookup tags alongside the ROM read so that each tag
// leaves the pipe in the same cycle its pixel bit is on rom_pixel.
//   clock_25 : clock
//   reset    : async active-low; clears every stage (in-flight reads dropped)
//   tag_in   : tag of the lookup accepted this cycle (valid=0 when idle)
//   tag_out  : tag aligned with the ROM data
module arb_tag_pipe
    import number_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock_25,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/number_glyph_arbiter.sv
// number_glyph_arbiter
// Shares the single-read-port digit glyph ROM between the time renderer (T)
// and the score renderer (S). One lookup is accepted per cycle; each accepted
// lookup is tagged and its pixel bit is routed back to the issuing port.
//   clock_25, reset              : clock, async active-low reset
//   t_req/t_digit/t_count        : time renderer lookup request (held until granted)
//   s_req/s_digit/s_count        : score renderer lookup request (held until granted)
//   t_gnt, s_gnt                 : combinational grants; accept on req & gnt
//   t_pixel_valid/t_pixel        : registered response pulse and glyph bit for T
//   s_pixel_valid/s_pixel        : registered response pulse and glyph bit for S
//   rom_en/rom_digit/rom_count   : registered ROM read strobe and address
//   rom_pixel                    : ROM data, ROM_LATENCY cycles after rom_en
module number_glyph_arbiter
    import number_pkg::*;
#(
    parameter int PIXEL_COUNT_BIT = 7,
    parameter int ROM_LATENCY     = 1,
    parameter int PRIORITY_MODE   = 0
) (
    input  logic                     clock_25,
    input  logic                     reset,
    input  logic                     t_req,
    input  logic [3:0]               t_digit,
    input  logic [PIXEL_COUNT_BIT:0] t_count,
    input  logic                     s_req,
    input  logic [3:0]               s_digit,
    input  logic [PIXEL_COUNT_BIT:0] s_count,
    output logic                     t_gnt,
    output logic                     s_gnt,
    output logic                     t_pixel_valid,
    output logic                     t_pixel,
    output logic                     s_pixel_valid,
    output logic                     s_pixel,
    output logic                     rom_en,
    output logic [3:0]               rom_digit,
    output logic [PIXEL_COUNT_BIT:0] rom_count,
    input  logic                     rom_pixel
);

    // Tag leaves stage ROM_LATENCY in the cycle rom_pixel carries its bit:
    // one stage covers the rom_en register, the rest cover the ROM latency.
    localparam int PIPE_DEPTH = ROM_LATENCY + 1;

    port_e                    last_q, last_d;
    logic                     accept;
    port_e                    sel_port;
    logic [3:0]               sel_digit;
    logic [PIXEL_COUNT_BIT:0] sel_count;
    logic                     sel_blank;

    logic                     rom_en_q, rom_en_d;
    logic [3:0]               rom_digit_q, rom_digit_d;
    logic [PIXEL_COUNT_BIT:0] rom_count_q, rom_count_d;

    logic                     t_pixel_valid_q, t_pixel_valid_d;
    logic                     t_pixel_q, t_pixel_d;
    logic                     s_pixel_valid_q, s_pixel_valid_d;
    logic                     s_pixel_q, s_pixel_d;

    tag_t                     tag_in, tag_out;

    // Grants are held low while reset is asserted so nothing is accepted
    // on the edge that releases it.
    always_comb begin
        t_gnt = 1'b0;
        s_gnt = 1'b0;
        if (reset) begin
            if (t_req && s_req) begin
                if ((PRIORITY_MODE != 0) || (last_q == PORT_S)) begin
                    t_gnt = 1'b1;
                end else begin
                    s_gnt = 1'b1;
                end
            end else begin
                t_gnt = t_req;
                s_gnt = s_req;
            end
        end
    end

    always_comb begin
        accept    = (t_req && t_gnt) || (s_req && s_gnt);
        sel_port  = s_gnt ? PORT_S : PORT_T;
        sel_digit = s_gnt ? s_digit : t_digit;
        sel_count = s_gnt ? s_count : t_count;
        sel_blank = lookup_blank(32'(sel_digit), 32'(sel_count));

        last_d    = accept ? sel_port : last_q;

        // Blank lookups still occupy a tag slot but never touch the ROM;
        // the address bus keeps its previous value.
        rom_en_d    = accept && !sel_blank;
        rom_digit_d = rom_en_d ? sel_digit : rom_digit_q;
        rom_count_d = rom_en_d ? sel_count : rom_count_q;

        tag_in.valid = accept;
        tag_in.port  = sel_port;
        tag_in.blank = sel_blank;
    end

    arb_tag_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_tag_pipe (
        .clock_25(clock_25),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        t_pixel_valid_d = tag_out.valid && (tag_out.port == PORT_T);
        s_pixel_valid_d = tag_out.valid && (tag_out.port == PORT_S);
        t_pixel_d       = t_pixel_valid_d && !tag_out.blank && rom_pixel;
        s_pixel_d       = s_pixel_valid_d && !tag_out.blank && rom_pixel;
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            last_q          <= PORT_S;
            rom_en_q        <= 1'b0;
            rom_digit_q     <= '0;
            rom_count_q     <= '0;
            t_pixel_valid_q <= 1'b0;
            t_pixel_q       <= 1'b0;
            s_pixel_valid_q <= 1'b0;
            s_pixel_q       <= 1'b0;
        end else begin
            last_q          <= last_d;
            rom_en_q        <= rom_en_d;
            rom_digit_q     <= rom_digit_d;
            rom_count_q     <= rom_count_d;
            t_pixel_valid_q <= t_pixel_valid_d;
            t_pixel_q       <= t_pixel_d;
            s_pixel_valid_q <= s_pixel_valid_d;
            s_pixel_q       <= s_pixel_d;
        end
    end

    assign rom_en        = rom_en_q;
    assign rom_digit     = rom_digit_q;
    assign rom_count     = rom_count_q;
    assign t_pixel_valid = t_pixel_valid_q;
    assign t_pixel       = t_pixel_q;
    assign s_pixel_valid = s_pixel_valid_q;
    assign s_pixel       = s_pixel_q;

endmodule

// File: doc/number_glyph_arbiter.md
# number_glyph_arbiter

- Shares the single-read-port digit glyph ROM between the time renderer (port T) and the score renderer (port S).
- Accepts pixel-lookup requests (digit, pixel index) from each renderer and arbitrates one ROM read per cycle.
- Tracks in-flight reads through the ROM latency and returns each pixel bit to the requester that issued it.
- Sits between the renderers and the number ROM in the `clock_25` VGA domain.

## Interface
- PIXEL_COUNT_BIT, 7: MSB of pixel-index buses (8-bit index).
- ROM_LATENCY, 1: cycles from `rom_en` high to `rom_pixel` valid; legal 1..3.
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority (T wins).
- clock_25  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low.
- t_req, s_req  input  1 each  request; held with stable operands until granted.
- t_digit, s_digit  input  4 each  digit to look up.
- t_count, s_count  input  8 each  pixel index in glyph, row-major, 0..159.
- t_gnt, s_gnt  output  1 each  combinational grant; request accepted on the edge where req&gnt.
- t_pixel_valid, s_pixel_valid  output  1 each  registered; one-cycle pulse per accepted request.
- t_pixel, s_pixel  output  1 each  registered glyph bit; 0 whenever the matching valid is 0.
- rom_en  output  1  registered ROM read strobe.
- rom_digit  output  4  registered ROM digit.
- rom_count  output  8  registered ROM pixel index.
- rom_pixel  input  1  ROM data, valid ROM_LATENCY cycles after rom_en.

## Operation
- At most one grant per cycle; `t_gnt` and `s_gnt` are never both 1.
- Grant requires the port's req = 1; no req, no grant.
- Round-robin: `last` register (reset = S), so T wins the first contention.
  - On contention, grant the port not equal to `last`.
  - `last` updates only on an accepted grant.
  - A lone requester is always granted.
- Fixed mode: T always wins contention; S is granted only when `t_req` = 0.
- Valid lookup (digit ≤ 9 and count ≤ 159):
  - Edge after acceptance: `rom_en` = 1, `rom_digit`/`rom_count` = granted operands.
- Invalid lookup (digit > 9 or count > 159):
  - Still granted, but `rom_en` stays 0.
  - Response is marked blank and returns pixel 0 with normal valid timing.
- Each accepted request pushes a tag {valid, port, blank} into a tag pipe whose alignment matches `rom_pixel`.
- On tag exit, the tagged port's `*_pixel_valid` is set, with `*_pixel` = blank ? 0 : `rom_pixel`.
- `rom_digit`/`rom_count` hold their last values when idle.
- No queueing inside the block: an ungranted requester simply holds req.

## Timing
- Request accepted in cycle t; `rom_en` high in t+1; `rom_pixel` sampled in t+1+ROM_LATENCY; `*_pixel_valid` high in t+2+ROM_LATENCY.
- Throughput is one lookup per cycle, sustained; back-to-back grants are legal, including alternating ports.
- Responses return in grant order; each port's responses are in its own request order.
- Reset values:
  - `t_gnt`, `s_gnt` = 0 (reset forces grant low).
  - `rom_en` = 0, `rom_digit` = 0, `rom_count` = 0.
  - All `*_pixel_valid` and `*_pixel` = 0.
  - Tag pipe all invalid; `last` = S.
- Reset mid-operation: in-flight tags are discarded; no valid pulse after reset release for pre-reset requests.
- Simultaneous request and return on the same port are independent; both occur.
- Count boundaries: 159 is valid, 160 is blank; digit 9 valid, 10 blank.

## Structure
- Shared package `number_pkg`:
  - GLYPH_W = 10, GLYPH_H = 16, GLYPH_PIXELS = 160, DIGIT_MAX = 9.
  - Port indices PORT_T = 0, PORT_S = 1.
  - Tag layout {valid, port, blank}.
- Sub-module `arb_tag_pipe`: parameterised shift register, depth ROM_LATENCY+1, carrying the tag; no reset-free stages.

## Test plan
- T only, digit 3, count 0..159 streamed back-to-back, ROM_LATENCY = 1 -> grant every cycle; `t_pixel_valid` from t+3; bits match ROM model; `s_pixel_valid` never 1.
- Both request continuously, RR mode -> grants alternate T, S, T, S starting with T; each port receives exactly its own bits, in order.
- Same stimulus with PRIORITY_MODE = 1 -> S never granted while `t_req` = 1; S granted on the first cycle `t_req` drops.
- T digit 12 count 5, then digit 9 count 160 -> both granted; `rom_en` stays 0; `t_pixel_valid` at t+2+L with `t_pixel` = 0.
- ROM_LATENCY = 3, 20 mixed T/S requests -> every valid at acceptance+5; no loss or reordering.
- Assert reset with 2 reads in flight -> all outputs 0 immediately; no valid pulse after release; first post-reset contention grants T.
